// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the multi-cycle ALU.
//   alu_op_e    - 4-bit opcode space (legacy 2-bit codes kept in the low values)
//   alu_state_e - top-level FSM states
//   FLAG_*      - bit positions inside the 4-bit ALUFlags vector
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_MUL  = 4'b1000,
    OP_DIVU = 4'b1001,
    OP_REMU = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Ops that run on the iterative datapath instead of the one-cycle path.
  function automatic logic is_iter_op(logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// alu_iter: shared iterative datapath for shift-add multiply and restoring
// unsigned divide, one bit per cycle, WIDTH iterations.
//   clk, rst_n  - clock, synchronous active-low reset
//   start       - load operands and begin (a, b, is_div sampled here)
//   is_div      - 1: divide (a / b), 0: multiply (a * b)
//   done        - high during the final iteration cycle
//   prod_lo     - low WIDTH bits of the product (valid with done)
//   quot, rem   - quotient and remainder (valid with done)
// Outputs are the post-step values of the current cycle, so the consumer can
// register them on the same edge that performs the last iteration.
module alu_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] prod_lo,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem
);
  localparam int CW = $clog2(WIDTH);

  // x: multiplier (shifts right) or dividend/quotient (shifts left)
  // y: multiplicand (shifts left) or divisor (static)
  // acc: product accumulator or partial remainder
  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d, acc_q, acc_d;

  logic [WIDTH-1:0] mul_acc_nxt;
  logic [WIDTH:0]   trial;
  logic [WIDTH+1:0] diff;
  logic             qbit;
  logic [WIDTH-1:0] rem_nxt, q_nxt;

  assign mul_acc_nxt = acc_q + (x_q[0] ? y_q : '0);

  // Restoring step: shift next dividend bit into the remainder, subtract the
  // divisor if it fits. A zero divisor always fits, which yields an all-ones
  // quotient and a remainder equal to the dividend without special casing.
  assign trial   = {acc_q, x_q[WIDTH-1]};
  assign diff    = {1'b0, trial} - {2'b00, y_q};
  assign qbit    = ~diff[WIDTH+1];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
  assign q_nxt   = {x_q[WIDTH-2:0], qbit};

  assign done    = busy_q && (cnt_q == CW'(WIDTH-1));
  assign prod_lo = mul_acc_nxt;
  assign quot    = q_nxt;
  assign rem     = rem_nxt;

  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    x_d    = x_q;
    y_d    = y_q;
    acc_d  = acc_q;
    if (start) begin
      busy_d = 1'b1;
      div_d  = is_div;
      cnt_d  = '0;
      x_d    = is_div ? a : b;
      y_d    = is_div ? b : a;
      acc_d  = '0;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) begin
        acc_d = rem_nxt;
        x_d   = q_nxt;
      end else begin
        acc_d = mul_acc_nxt;
        x_d   = x_q >> 1;
        y_d   = y_q << 1;
      end
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      x_q    <= x_d;
      y_q    <= y_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready on both sides.
//   clk, rst_n          - clock, synchronous active-low reset
//   InValid/InReady     - operand handshake; InReady only in IDLE
//   SrcA, SrcB          - operands; ALUControl - 4-bit opcode
//   OutValid/OutReady   - result handshake
//   ALUResult, ALUFlags - registered result and {N,Z,C,V}
// One-cycle ops are computed from the live inputs and registered on accept;
// MUL/DIVU/REMU are handed to alu_iter and registered on its last step.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic [3:0]       ALUFlags
);
  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flags_q, flags_d;

  logic             accept;
  logic [WIDTH:0]   sum, diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] sc_res, it_res;
  logic             sc_c, sc_v;
  logic             it_done;
  logic [WIDTH-1:0] it_prod, it_quot, it_rem;

  // Gating with rst_n keeps InReady low in the reset cycle itself.
  assign InReady   = rst_n && (state_q == ST_IDLE);
  assign accept    = InValid && InReady;
  assign OutValid  = (state_q == ST_DONE);
  assign ALUResult = res_q;
  assign ALUFlags  = flags_q;

  assign sum   = {1'b0, SrcA} + {1'b0, SrcB};
  assign diff  = {1'b0, SrcA} - {1'b0, SrcB};
  assign shamt = SrcB[SHW-1:0];

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (ALUControl)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = ~diff[WIDTH];  // carry = NOT borrow
        sc_v   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
      end
      OP_AND:  sc_res = SrcA & SrcB;
      OP_OR:   sc_res = SrcA | SrcB;
      OP_XOR:  sc_res = SrcA ^ SrcB;
      OP_SLL:  sc_res = SrcA << shamt;
      OP_SRL:  sc_res = SrcA >> shamt;
      OP_SRA:  sc_res = $signed(SrcA) >>> shamt;
      default: sc_res = '0;  // reserved ops yield 0, hence Z=1
    endcase
  end

  always_comb begin
    case (op_q)
      OP_MUL:  it_res = it_prod;
      OP_DIVU: it_res = it_quot;
      default: it_res = it_rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    res_d   = res_q;
    flags_d = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d = ALUControl;
          if (is_iter_op(ALUControl)) begin
            state_d = ST_BUSY;
          end else begin
            state_d = ST_DONE;
            res_d   = sc_res;
            flags_d = {sc_res[WIDTH-1], ~|sc_res, sc_c, sc_v};
          end
        end
      end
      ST_BUSY: begin
        if (it_done) begin
          state_d = ST_DONE;
          res_d   = it_res;
          flags_d = {it_res[WIDTH-1], ~|it_res, 1'b0, 1'b0};
        end
      end
      ST_DONE: if (OutReady) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_ADD;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_iter_op(ALUControl)),
    .is_div  (ALUControl != OP_MUL),
    .a       (SrcA),
    .b       (SrcB),
    .done    (it_done),
    .prod_lo (it_prod),
    .quot    (it_quot),
    .rem     (it_rem)
  );

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed bench for alu_mc with a 64-bit and a 32-bit instance.
// Expected results are queued when an op is driven and popped on OutValid.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv64, iv32, out_ready;
  logic [63:0] src_a, src_b;
  logic [3:0]  ctrl;
  logic        ir64, ir32, ov64, ov32;
  logic [63:0] res64;
  logic [31:0] res32;
  logic [3:0]  fl64, fl32;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [63:0] res;
    logic [3:0]  flg;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(64)) dut64 (
    .clk(clk), .rst_n(rst_n), .InValid(iv64), .InReady(ir64),
    .SrcA(src_a), .SrcB(src_b), .ALUControl(ctrl),
    .OutValid(ov64), .OutReady(out_ready), .ALUResult(res64), .ALUFlags(fl64)
  );

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .InValid(iv32), .InReady(ir32),
    .SrcA(src_a[31:0]), .SrcB(src_b[31:0]), .ALUControl(ctrl),
    .OutValid(ov32), .OutReady(out_ready), .ALUResult(res32), .ALUFlags(fl32)
  );

  function automatic logic ov(bit w32);
    return w32 ? ov32 : ov64;
  endfunction
  function automatic logic rdy(bit w32);
    return w32 ? ir32 : ir64;
  endfunction
  function automatic logic [63:0] res(bit w32);
    return w32 ? {32'h0, res32} : res64;
  endfunction
  function automatic logic [3:0] flg(bit w32);
    return w32 ? fl32 : fl64;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one op, wait for OutValid within a bound, check latency, that
  // InReady stayed low while busy, and the queued result/flags. If OutReady
  // is high also check the return to IDLE one cycle later.
  task automatic do_op(input bit w32, input logic [3:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] er, input logic [3:0] ef,
                       input int elat, input string tag);
    exp_t e;
    int   lat;
    bit   rdy_low;
    chk({tag, " ready_before"}, 64'(rdy(w32)), 64'd1);
    src_a = a; src_b = b; ctrl = op;
    if (w32) iv32 = 1'b1; else iv64 = 1'b1;
    sb.push_back('{er, ef});
    @(posedge clk); #1;
    iv32 = 1'b0; iv64 = 1'b0;
    lat = 1;
    rdy_low = 1'b1;
    while (!ov(w32) && lat < 200) begin
      if (rdy(w32)) rdy_low = 1'b0;
      // Scribble the inputs while the op is in flight; they must not matter.
      src_a = {$urandom, $urandom};
      src_b = {$urandom, $urandom};
      ctrl  = 4'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " ready_low_busy"}, 64'(rdy_low), 64'd1);
    chk({tag, " ready_low_done"}, 64'(rdy(w32)), 64'd0);
    e = sb.pop_front();
    chk({tag, " result"}, res(w32), e.res);
    chk({tag, " flags"}, 64'(flg(w32)), 64'(e.flg));
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, " out_valid_drop"}, 64'(ov(w32)), 64'd0);
      chk({tag, " ready_back"}, 64'(rdy(w32)), 64'd1);
    end
  endtask

  initial begin
    rst_n = 1'b0; iv64 = 1'b0; iv32 = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; ctrl = '0;
    #1;
    chk("reset_cycle_ready", 64'(ir64), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(ov64), 64'd0);
    chk("reset_result", res64, 64'd0);
    chk("reset_flags", 64'(fl64), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 64'(ir64), 64'd1);

    // One-cycle ops
    do_op(0, 4'b0000, 64'd105, 64'd215, 64'd320, 4'b0000, 1, "add");
    do_op(0, 4'b0001, 64'd105, 64'd105, 64'd0, 4'b0110, 1, "sub_zero");
    do_op(0, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 4'b1001, 1, "add_ovf");
    do_op(0, 4'b0001, 64'd5, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1, "sub_borrow");
    do_op(0, 4'b0010, 64'hF0, 64'hFF, 64'hF0, 4'b0000, 1, "and");
    do_op(0, 4'b0011, 64'hF0, 64'h0F, 64'hFF, 4'b0000, 1, "or");
    do_op(0, 4'b0101, 64'd1, 64'd65, 64'd2, 4'b0000, 1, "sll_wrap_amt");
    do_op(0, 4'b0110, 64'h8000_0000_0000_0000, 64'd63, 64'd1, 4'b0000, 1, "srl");
    do_op(0, 4'b0111, 64'h8000_0000_0000_0000, 64'd63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 1, "sra");
    do_op(0, 4'b1111, 64'd9, 64'd9, 64'd0, 4'b0100, 1, "reserved");

    // Iterative ops
    do_op(0, 4'b1000, 64'd12345, 64'd678, 64'd8369910, 4'b0000, 65, "mul");
    do_op(0, 4'b1001, 64'd100, 64'd7, 64'd14, 4'b0000, 65, "divu");
    do_op(0, 4'b1010, 64'd100, 64'd7, 64'd2, 4'b0000, 65, "remu");
    do_op(0, 4'b1001, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000, 65, "divu_zero");
    do_op(0, 4'b1010, 64'd100, 64'd0, 64'd100, 4'b0000, 65, "remu_zero");

    // Backpressure
    out_ready = 1'b0;
    do_op(0, 4'b0100, 64'hF0, 64'hFF, 64'h0F, 4'b0000, 1, "xor_bp");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_result", res64, 64'h0F);
      chk("bp_out_valid", 64'(ov64), 64'd1);
      chk("bp_ready", 64'(ir64), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 64'(ov64), 64'd0);
    chk("bp_release_ready", 64'(ir64), 64'd1);

    // Reset in the middle of a MUL
    src_a = 64'd3; src_b = 64'd4; ctrl = 4'b1000; iv64 = 1'b1;
    @(posedge clk); #1;
    iv64 = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("mid_mul_busy", 64'(ir64), 64'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_valid", 64'(ov64), 64'd0);
    chk("midrst_result", res64, 64'd0);
    chk("midrst_flags", 64'(fl64), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(0, 4'b0000, 64'd1, 64'd2, 64'd3, 4'b0000, 1, "add_after_rst");

    // 32-bit instance
    do_op(1, 4'b0000, 64'hFFFF_FFFF, 64'd1, 64'd0, 4'b0110, 1, "add32_wrap");
    do_op(1, 4'b1000, 64'd3, 64'd5, 64'd15, 4'b0000, 33, "mul32");
    do_op(1, 4'b1001, 64'hFFFF_FFFF, 64'd16, 64'h0FFF_FFFF, 4'b0000, 33, "divu32");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised, multi-cycle successor to the single-cycle `Alu`, generalised to any `WIDTH` and a 4-bit opcode space. Single-cycle ops (add/sub/logic/shift) return one cycle after acceptance. MUL, DIVU and REMU run on an iterative datapath over `WIDTH` cycles. Both sides use valid/ready handshakes, so the block sits in the execute stage and can stall the pipeline during long ops.

## Interface
- `WIDTH`, default 64: operand/result width; any value ≥ 8 that is a power of two.
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `InValid` in 1: operands and opcode are valid.
- `InReady` out 1: block can accept an op; 1 only in IDLE.
- `SrcA` in WIDTH: operand A.
- `SrcB` in WIDTH: operand B.
- `ALUControl` in 4: opcode.
- `OutValid` out 1: result and flags are valid.
- `OutReady` in 1: consumer takes the result.
- `ALUResult` out WIDTH: registered result.
- `ALUFlags` out 4: bit [3]=N, [2]=Z, [1]=C, [0]=V; registered.

## Operation
- Opcodes keep the legacy 2-bit codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA, 1000 MUL (low WIDTH bits of the product), 1001 DIVU, 1010 REMU.
- Reserved opcodes: result 0, flags 0100.
- Accept occurs when `InValid && InReady` at a clock edge. `SrcA`, `SrcB` and `ALUControl` are captured then; later input changes have no effect.
- Shifts use `SrcB[$clog2(WIDTH)-1:0]`; upper bits are ignored.
- MUL uses shift-add, one bit per cycle, `WIDTH` iterations.
- DIVU/REMU use restoring division, one quotient bit per cycle, `WIDTH` iterations.
- Divide by zero: DIVU returns all ones; REMU returns `SrcA`. No trap.
- Flags:
  - N = result MSB; Z = (result == 0).
  - ADD: C = carry-out; V = signed overflow.
  - SUB: C = NOT borrow (1 when `SrcA >= SrcB` unsigned); V = signed overflow.
  - All other ops: C = V = 0.
- FSM:
  - IDLE: on accept, go to DONE for single-cycle ops, or BUSY for MUL/DIVU/REMU with the iteration counter cleared.
  - BUSY: increment the counter each cycle; when the counter reaches `WIDTH-1`, load the result and go to DONE.
  - DONE: `OutValid`=1; when `OutReady`=1, go to IDLE.
- `InReady`=0 in BUSY and DONE. No same-cycle accept while leaving DONE.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, counter 0, `OutValid`=0, `ALUResult`=0, `ALUFlags`=0.
- `InReady` is 0 during the reset cycle and 1 from the first edge with `rst_n`=1.
- Reset mid-BUSY or mid-DONE: the in-flight op is discarded with no output; the next op behaves normally.
- Single-cycle op latency: `OutValid` rises 1 cycle after accept.
- MUL/DIVU/REMU latency: `OutValid` rises `WIDTH`+1 cycles after accept (65 for `WIDTH`=64).
- Backpressure: while `OutValid`=1 and `OutReady`=0, `ALUResult` and `ALUFlags` hold stable.
- `OutReady` asserted earlier than `OutValid` has no effect.
- Throughput: at most one op per 2 cycles (accept, then DONE→IDLE).
- ADD/SUB wrap modulo 2^WIDTH.

## Structure
- Package `alu_pkg`:
  - `alu_op_e` opcode enum (4-bit);
  - `alu_state_e` (IDLE, BUSY, DONE);
  - flag index constants `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V`.
- Sub-module `alu_iter`, parametrised by `WIDTH`:
  - shared shift register/accumulator for MUL and restoring DIV;
  - start/done interface, counter internal;
  - outputs product-low, quotient and remainder.
- Top level `alu_mc` holds the FSM, the combinational single-cycle datapath, flag generation and the output registers.

## Test plan
- ADD 105+215, `OutReady`=1 → `ALUResult`=320, flags 0000, `OutValid` 1 cycle after accept, `InReady` back to 1 one cycle later.
- SUB 105−105 → result 0, flags 0110 (Z, C). ADD 0x7FFF_FFFF_FFFF_FFFF+1 → 0x8000_0000_0000_0000, flags 1001 (N, V).
- MUL 12345×678 → 8369910. `OutValid` exactly 65 cycles after accept; `InReady`=0 throughout; mid-op changes to `SrcA`/`SrcB` ignored.
- DIVU 100/7 → 14; REMU 100%7 → 2; DIVU 100/0 → all ones; REMU 100%0 → 100. SRA 0x8000…0 by 63 → all ones, N=1.
- Backpressure and reset:
  - hold `OutReady`=0 for 5 cycles after XOR 0xF0^0xFF → `ALUResult`=0x0F stable, `OutValid`=1, `InReady`=0; the op completes on `OutReady`.
  - assert `rst_n`=0 20 cycles into a MUL → next edge `OutValid`=0, outputs 0; after release, an ADD 1+2 returns 3 with 1-cycle latency.
- `WIDTH`=32 instance: ADD 0xFFFF_FFFF+1 → 0, flags 0110; MUL latency 33 cycles.
